// File: rtl/cnt_seq_pkg.sv
// Shared types, direction constants and default widths for the counter sequencer.
// Used by cnt_seq_ctrl, its interface and its arbiter.
package cnt_seq_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int LEN_W_DEF   = 4;
    localparam int ID_W_DEF    = 2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_seq_state_t;

    // Requester index following idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// Requester and counter-side signals of the counter sequencer.
// The master modport is the requester/counter side; the slave modport is cnt_seq_ctrl.
interface cnt_seq_ctrl_if
    import cnt_seq_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int ID_W    = ID_W_DEF
);
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ-1:0]       dir_i;
    logic [NUM_REQ*LEN_W-1:0] len_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     sel_o;
    logic                     en_o;
    logic                     busy_o;
    logic [ID_W-1:0]          active_id_o;

    modport master (
        output req_i, dir_i, len_i,
        input  gnt_o, done_o, sel_o, en_o, busy_o, active_id_o
    );

    modport slave (
        input  req_i, dir_i, len_i,
        output gnt_o, done_o, sel_o, en_o, busy_o, active_id_o
    );
endinterface

// File: rtl/cnt_seq_rr_arb.sv
// Combinational winner select for the counter sequencer: round robin from ptr,
// or lowest-index-wins when CNT_SEQ_FIXED_PRIO_EN is defined.
module cnt_seq_rr_arb
    import cnt_seq_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [ID_W-1:0]    win_id,
    output logic               valid
);

`ifdef CNT_SEQ_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scan downwards so the lowest active index is the last one written.
    always_comb begin
        win_oh = '0;
        win_id = '0;
        valid  = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end
`else
    // Scan offsets downwards so the request closest to ptr (wrapping) wins.
    always_comb begin
        win_oh = '0;
        win_id = '0;
        valid  = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                win_oh      = '0;
                win_oh[idx] = 1'b1;
                win_id      = ID_W'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequences a shared up/down counter for NUM_REQ requesters: arbitrates, then drives
// sel/en for exactly len cycles. Define CNT_SEQ_FIXED_PRIO_EN for fixed priority.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    cnt_seq_ctrl_if.slave bus
);

    cnt_seq_state_t     state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [ID_W-1:0]    ptr_q;

    logic [NUM_REQ-1:0] win_oh;
    logic [ID_W-1:0]    win_id;
    logic               win_valid;
    logic [LEN_W-1:0]   win_len;
    logic               abort;

    cnt_seq_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (bus.req_i),
        .ptr    (ptr_q),
        .win_oh (win_oh),
        .win_id (win_id),
        .valid  (win_valid)
    );

    assign win_len = bus.len_i[int'(win_id)*LEN_W +: LEN_W];
    // Owner let go of its request mid-run: drop the run without a done pulse.
    assign abort   = (state_q == RUN) && !bus.req_i[id_q];

`ifdef CNT_SEQ_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if ((state_q == DONE) || abort) begin
            ptr_q <= ID_W'(wrap_inc(int'(id_q), NUM_REQ));
        end
    end
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d = state_q;
        gnt_d   = '0;
        done_d  = '0;
        en_d    = 1'b0;
        sel_d   = sel_q;
        id_d    = id_q;
        rem_d   = rem_q;

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    id_d  = win_id;
                    sel_d = bus.dir_i[win_id];
                    if (win_len != '0) begin
                        state_d = RUN;
                        gnt_d   = win_oh;
                        en_d    = 1'b1;
                        rem_d   = win_len;
                    end else begin
                        state_d = DONE;
                        done_d  = win_oh;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (rem_q == LEN_W'(1)) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                    rem_d   = '0;
                end else begin
                    gnt_d = gnt_q;
                    en_d  = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            sel_q   <= DIR_DOWN;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            id_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            id_q    <= id_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.done_o      = done_q;
    assign bus.sel_o       = sel_q;
    assign bus.en_o        = en_q;
    assign bus.busy_o      = busy_q;
    assign bus.active_id_o = id_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: directed scenarios plus randomized batches
// checked against a transaction-level arbitration model.
module tb_cnt_seq_ctrl;
    import cnt_seq_pkg::*;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ptr_m  = 0;

    typedef struct {
        int         id;
        int         lat;
        int         en;
        int         aid;
        logic [N-1:0] done;
        logic [N-1:0] gnt_any;
        logic       sel;
        bit         sel_stable;
        bit         timeout;
    } obs_t;

    cnt_seq_ctrl_if #(.NUM_REQ(N), .LEN_W(LW), .ID_W(IW)) bus ();

    cnt_seq_ctrl #(.NUM_REQ(N), .LEN_W(LW), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Winner rule: first pending requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
`ifdef CNT_SEQ_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (pend[i]) return i;
`else
        for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return -1;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_len(input int k, input int v);
        bus.len_i[k*LW +: LW] = LW'(v);
    endtask

    // Watches one run from the current negedge until its done pulse or abort.
    task automatic run_obs(input bit drop_on_done, input bit scramble, output obs_t o);
        bit started = 1'b0;
        bit fin     = 1'b0;
        int cyc     = 0;
        o = '{id: -1, lat: -1, en: 0, aid: -1, done: '0, gnt_any: '0,
              sel: 1'b0, sel_stable: 1'b1, timeout: 1'b0};
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!started && (bus.gnt_o != '0 || bus.done_o != '0)) begin
                started = 1'b1;
                o.lat   = cyc;
                o.sel   = bus.sel_o;
                o.aid   = int'(bus.active_id_o);
            end
            if (started) begin
                o.gnt_any |= bus.gnt_o;
                if (bus.en_o) begin
                    o.en++;
                    if (bus.sel_o !== o.sel) o.sel_stable = 1'b0;
                end
                if (bus.done_o != '0) begin
                    o.done = bus.done_o;
                    o.id   = oh2idx(bus.done_o);
                    fin    = 1'b1;
                    if (drop_on_done) bus.req_i &= ~bus.done_o;
                end else if (bus.gnt_o == '0) begin
                    fin = 1'b1;
                end else begin
                    o.id = oh2idx(bus.gnt_o);
                end
                if (scramble && !fin) begin
                    bus.dir_i = N'($urandom);
                    bus.len_i = (N*LW)'($urandom);
                end
            end
        end
        o.timeout = !fin;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_i = '0;
        bus.dir_i = '0;
        bus.len_i = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.gnt_o !== '0) begin errors++; $display("FAIL reset_gnt got %b exp 0", bus.gnt_o); end
        checks++; if (bus.done_o !== '0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done_o); end
        checks++; if (bus.sel_o !== 1'b0) begin errors++; $display("FAIL reset_sel got %b exp 0", bus.sel_o); end
        checks++; if (bus.en_o !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", bus.en_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
        checks++; if (bus.active_id_o !== '0) begin errors++; $display("FAIL reset_aid got %0d exp 0", bus.active_id_o); end
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_single();
        obs_t o;
        bus.dir_i = 4'b0001;
        set_len(0, 3);
        bus.req_i = 4'b0001;
        run_obs(1'b1, 1'b0, o);
        checks++; if (o.timeout) begin errors++; $display("FAIL single_timeout got timeout exp done"); end
        checks++; if (o.lat !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", o.lat); end
        checks++; if (o.gnt_any !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", o.gnt_any); end
        checks++; if (o.en !== 3) begin errors++; $display("FAIL single_en_cycles got %0d exp 3", o.en); end
        checks++; if (o.sel !== DIR_UP || !o.sel_stable) begin errors++; $display("FAIL single_sel got %b stable %0d exp 1", o.sel, o.sel_stable); end
        checks++; if (o.done !== 4'b0001) begin errors++; $display("FAIL single_done got %b exp 0001", o.done); end
        checks++; if (o.aid !== 0) begin errors++; $display("FAIL single_aid got %0d exp 0", o.aid); end
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b exp 0", bus.busy_o); end
        checks++; if (bus.done_o !== '0) begin errors++; $display("FAIL single_done_pulse got %b exp 0", bus.done_o); end
        ptr_m = 1;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   exp;
        logic [N-1:0] dirs;
        dirs = N'($urandom);
        bus.dir_i = dirs;
        for (int k = 0; k < N; k++) set_len(k, 2);
        bus.req_i = '1;
        for (int r = 0; r < 5; r++) begin
            exp = model_pick('1, ptr_m);
            run_obs(1'b0, 1'b0, o);
            checks++; if (o.id !== exp) begin errors++; $display("FAIL b2b_order run %0d got %0d exp %0d", r, o.id, exp); end
            checks++; if (o.en !== 2) begin errors++; $display("FAIL b2b_en run %0d got %0d exp 2", r, o.en); end
            checks++; if (o.sel !== dirs[exp]) begin errors++; $display("FAIL b2b_sel run %0d got %b exp %b", r, o.sel, dirs[exp]); end
            checks++; if (o.gnt_any !== N'(1 << exp)) begin errors++; $display("FAIL b2b_gnt run %0d got %b exp %b", r, o.gnt_any, N'(1 << exp)); end
            ptr_m = (exp + 1) % N;
            if (o.timeout) break;
        end
        bus.req_i = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_len_zero();
        obs_t o;
        set_len(2, 0);
        bus.req_i = 4'b0100;
        run_obs(1'b1, 1'b0, o);
        checks++; if (o.done !== 4'b0100) begin errors++; $display("FAIL len0_done got %b exp 0100", o.done); end
        checks++; if (o.lat !== 1) begin errors++; $display("FAIL len0_latency got %0d exp 1", o.lat); end
        checks++; if (o.en !== 0) begin errors++; $display("FAIL len0_en got %0d exp 0", o.en); end
        checks++; if (o.gnt_any !== '0) begin errors++; $display("FAIL len0_gnt got %b exp 0", o.gnt_any); end
        ptr_m = 3;
    endtask

    task automatic test_abort();
        obs_t o;
        int   en_seen = 0;
        int   cyc = 0;
        int   exp;
        logic [N-1:0] pend;
        bus.dir_i = N'($urandom);
        set_len(1, 8);
        bus.req_i = 4'b0010;
        while (en_seen < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.en_o) en_seen++;
        end
        checks++; if (en_seen !== 3) begin errors++; $display("FAIL abort_start got %0d en cycles exp 3", en_seen); end
        set_len(0, 2);
        set_len(2, 2);
        bus.req_i = 4'b0101;
        @(negedge clk);
        checks++; if (bus.en_o !== 1'b0) begin errors++; $display("FAIL abort_en got %b exp 0", bus.en_o); end
        checks++; if (bus.gnt_o !== '0) begin errors++; $display("FAIL abort_gnt got %b exp 0", bus.gnt_o); end
        checks++; if (bus.done_o !== '0) begin errors++; $display("FAIL abort_done got %b exp 0", bus.done_o); end
        ptr_m = 2;
        pend  = 4'b0101;
        for (int r = 0; r < 2; r++) begin
            exp = model_pick(pend, ptr_m);
            run_obs(1'b1, 1'b0, o);
            checks++; if (o.id !== exp) begin errors++; $display("FAIL abort_next run %0d got %0d exp %0d", r, o.id, exp); end
            checks++; if (o.en !== 2) begin errors++; $display("FAIL abort_next_en run %0d got %0d exp 2", r, o.en); end
            pend[exp] = 1'b0;
            ptr_m = (exp + 1) % N;
        end
        bus.req_i = '0;
    endtask

    task automatic test_reset_mid_run();
        obs_t o;
        int   en_seen = 0;
        int   cyc = 0;
        bus.dir_i = N'($urandom);
        set_len(0, 10);
        bus.req_i = 4'b0001;
        while (en_seen < 4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.en_o) en_seen++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.en_o !== 1'b0 || bus.gnt_o !== '0) begin errors++; $display("FAIL rstmid_en_gnt got en %b gnt %b exp 0 0", bus.en_o, bus.gnt_o); end
        checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== '0) begin errors++; $display("FAIL rstmid_busy_done got busy %b done %b exp 0 0", bus.busy_o, bus.done_o); end
        checks++; if (bus.sel_o !== 1'b0 || bus.active_id_o !== '0) begin errors++; $display("FAIL rstmid_sel_aid got sel %b aid %0d exp 0 0", bus.sel_o, bus.active_id_o); end
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        run_obs(1'b1, 1'b0, o);
        checks++; if (o.id !== 0 || o.lat !== 1) begin errors++; $display("FAIL rstmid_regrant got id %0d lat %0d exp 0 1", o.id, o.lat); end
        checks++; if (o.en !== 10) begin errors++; $display("FAIL rstmid_full_len got %0d exp 10", o.en); end
        ptr_m = 1;
    endtask

    task automatic test_dir_latch();
        obs_t o;
        bus.dir_i = 4'b0111;
        set_len(3, 6);
        bus.req_i = 4'b1000;
        run_obs(1'b1, 1'b1, o);
        checks++; if (o.id !== 3) begin errors++; $display("FAIL dirlatch_id got %0d exp 3", o.id); end
        checks++; if (o.sel !== DIR_DOWN || !o.sel_stable) begin errors++; $display("FAIL dirlatch_sel got %b stable %0d exp 0 stable", o.sel, o.sel_stable); end
        checks++; if (o.en !== 6) begin errors++; $display("FAIL dirlatch_en got %0d exp 6", o.en); end
        ptr_m = 0;
    endtask

    task automatic test_random();
        obs_t o;
        int   exp;
        int   lens [N];
        logic [N-1:0] pend;
        logic [N-1:0] dirs;
        for (int b = 0; b < 20; b++) begin
            pend = N'($urandom_range(1, (1 << N) - 1));
            dirs = N'($urandom);
            for (int k = 0; k < N; k++) begin
                lens[k] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, (1 << LW) - 1));
                set_len(k, lens[k]);
            end
            bus.dir_i = dirs;
            bus.req_i = pend;
            while (pend != '0) begin
                exp = model_pick(pend, ptr_m);
                run_obs(1'b1, 1'b0, o);
                checks++; if (o.id !== exp || o.timeout) begin errors++; $display("FAIL rand_winner batch %0d got %0d exp %0d", b, o.id, exp); end
                checks++; if (o.en !== lens[exp]) begin errors++; $display("FAIL rand_en batch %0d got %0d exp %0d", b, o.en, lens[exp]); end
                checks++; if (o.done !== N'(1 << exp)) begin errors++; $display("FAIL rand_done batch %0d got %b exp %b", b, o.done, N'(1 << exp)); end
                checks++; if (o.aid !== exp) begin errors++; $display("FAIL rand_aid batch %0d got %0d exp %0d", b, o.aid, exp); end
                if (lens[exp] != 0) begin
                    checks++; if (o.sel !== dirs[exp]) begin errors++; $display("FAIL rand_sel batch %0d got %b exp %b", b, o.sel, dirs[exp]); end
                end
                pend[exp] = 1'b0;
                ptr_m = (exp + 1) % N;
                if (o.timeout) begin
                    pend = '0;
                    bus.req_i = '0;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single();
        test_back_to_back();
        test_len_zero();
        test_abort();
        test_reset_mid_run();
        test_dir_latch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
